// File: rtl/au_pkg.sv
// Shared definitions for the arithmetic-unit leaf blocks: architecture selectors
// and the result-width helper used to size encoded bit indices.
package au_pkg;

  localparam int ARCH_SCAN = 0;
  localparam int ARCH_TREE = 1;

  // max(ceil(log2(value)), 1): a 1-bit result is still needed for value = 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/au_int_log2_node.sv
// Two-input merge cell of the leading-one tree: forwards the upper half's index
// when the upper half holds a set bit, and records that choice at bit LVL.
module au_int_log2_node #(
  parameter int IW  = 1,
  parameter int LVL = 0
) (
  input  logic          vld_lo_i,
  input  logic          vld_hi_i,
  input  logic [IW-1:0] idx_lo_i,
  input  logic [IW-1:0] idx_hi_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  // Indices are carried at full width with bits LVL and above still zero, so
  // writing the select bit at LVL is the same as forming {sel_upper, index}.
  always_comb begin
    vld_o      = vld_lo_i | vld_hi_i;
    idx_o      = vld_hi_i ? idx_hi_i : idx_lo_i;
    idx_o[LVL] = vld_hi_i;
  end

endmodule

// File: rtl/au_int_log2.sv
// Integer floor(log2(a)): index of the most significant set bit (0 for a = 0),
// built as a linear scan or a log-depth tree, with an optional output register.
module au_int_log2
  import au_pkg::*;
#(
  parameter int  WIDTH   = 8,
  parameter int  ARCH    = 0,
  parameter int  OUT_REG = 0,
  localparam int ZW      = clogb2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [ZW-1:0]    z
);

  logic [ZW-1:0] z_d;

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("au_int_log2: WIDTH %0d outside 1..1024", WIDTH);
  end

  if (ARCH == ARCH_SCAN) begin : g_scan
    // Later (higher) set bits overwrite earlier ones: a priority chain.
    always_comb begin
      z_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (a[i]) z_d = ZW'(i);
      end
    end
  end else if (ARCH == ARCH_TREE) begin : g_tree
    localparam int P = 1 << ZW;

    logic [P-1:0]  a_pad;
    logic          vld_lvl [ZW+1][P];
    logic [ZW-1:0] idx_lvl [ZW+1][P];

    // Pad bits are zero, so they never win a node and cannot yield index >= WIDTH.
    always_comb begin
      a_pad            = '0;
      a_pad[WIDTH-1:0] = a;
    end

    for (genvar j = 0; j < P; j++) begin : g_leaf
      assign vld_lvl[0][j] = a_pad[j];
      assign idx_lvl[0][j] = '0;
    end

    for (genvar l = 0; l < ZW; l++) begin : g_lvl
      for (genvar j = 0; j < (P >> (l + 1)); j++) begin : g_node
        au_int_log2_node #(
          .IW  (ZW),
          .LVL (l)
        ) u_node (
          .vld_lo_i (vld_lvl[l][2*j]),
          .vld_hi_i (vld_lvl[l][2*j+1]),
          .idx_lo_i (idx_lvl[l][2*j]),
          .idx_hi_i (idx_lvl[l][2*j+1]),
          .vld_o    (vld_lvl[l+1][j]),
          .idx_o    (idx_lvl[l+1][j])
        );
      end
    end

    assign z_d = idx_lvl[ZW][0];
  end else begin : g_bad_arch
    $error("au_int_log2: ARCH %0d is not a supported implementation", ARCH);
    assign z_d = '0;
  end

  if (OUT_REG != 0) begin : g_reg
    logic [ZW-1:0] z_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) z_q <= '0;
      else     z_q <= z_d;
    end

    assign z = z_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign z              = z_d;
  end

endmodule

// File: tb/tb_au_int_log2.sv
// Bench for au_int_log2 across widths 1/5/8/32, both architectures, and the
// registered 16-bit variant, against a halving-based floor(log2) model.
module tb_au_int_log2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [7:0]  a8;
  logic [4:0]  a5;
  logic [0:0]  a1;
  logic [31:0] a32;
  logic [15:0] a16;

  logic [2:0] z8s, z8t, z5s, z5t;
  logic [0:0] z1s, z1t;
  logic [4:0] z32s, z32t;
  logic [3:0] z16s, z16t;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  au_int_log2 #(.WIDTH(8),  .ARCH(0), .OUT_REG(0)) u8s  (.clk(clk), .rst(rst), .a(a8),  .z(z8s));
  au_int_log2 #(.WIDTH(8),  .ARCH(1), .OUT_REG(0)) u8t  (.clk(clk), .rst(rst), .a(a8),  .z(z8t));
  au_int_log2 #(.WIDTH(5),  .ARCH(0), .OUT_REG(0)) u5s  (.clk(clk), .rst(rst), .a(a5),  .z(z5s));
  au_int_log2 #(.WIDTH(5),  .ARCH(1), .OUT_REG(0)) u5t  (.clk(clk), .rst(rst), .a(a5),  .z(z5t));
  au_int_log2 #(.WIDTH(1),  .ARCH(0), .OUT_REG(0)) u1s  (.clk(clk), .rst(rst), .a(a1),  .z(z1s));
  au_int_log2 #(.WIDTH(1),  .ARCH(1), .OUT_REG(0)) u1t  (.clk(clk), .rst(rst), .a(a1),  .z(z1t));
  au_int_log2 #(.WIDTH(32), .ARCH(0), .OUT_REG(0)) u32s (.clk(clk), .rst(rst), .a(a32), .z(z32s));
  au_int_log2 #(.WIDTH(32), .ARCH(1), .OUT_REG(0)) u32t (.clk(clk), .rst(rst), .a(a32), .z(z32t));
  au_int_log2 #(.WIDTH(16), .ARCH(0), .OUT_REG(1)) u16s (.clk(clk), .rst(rst), .a(a16), .z(z16s));
  au_int_log2 #(.WIDTH(16), .ARCH(1), .OUT_REG(1)) u16t (.clk(clk), .rst(rst), .a(a16), .z(z16t));

  // floor(log2(v)) by repeated halving; 0 maps to 0.
  function automatic int unsigned ref_log2(input longint unsigned v);
    int unsigned r;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  dir_a [6];
    int unsigned dir_z [6];
    logic [15:0] v16;
    dir_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'hFF};
    dir_z = '{0, 0, 1, 1, 7, 7};
    a8 = '0; a5 = '0; a1 = '0; a32 = '0; a16 = 16'h0400;

    // Registered variant: asynchronous reset, latency, mid-stream reset.
    #1 rst = 1'b1;
    #1;
    chk("reg_rst_noclk_s", z16s, 0);
    chk("reg_rst_noclk_t", z16t, 0);
    @(negedge clk);
    rst = 1'b0;
    a16 = 16'h0400;
    #1;
    chk("reg_before_edge", z16t, 0);
    @(posedge clk); #1;
    chk("reg_lat1_s", z16s, 10);
    chk("reg_lat1_t", z16t, 10);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v16 = 16'($urandom) >> $urandom_range(0, 15);
      a16 = v16;
      @(posedge clk); #1;
      chk("reg_rand_s", z16s, ref_log2(v16));
      chk("reg_rand_t", z16t, ref_log2(v16));
    end
    a16 = 16'h8000;
    #2 rst = 1'b1;
    #1;
    chk("reg_midrst_s", z16s, 0);
    chk("reg_midrst_t", z16t, 0);
    @(posedge clk); #1;
    chk("reg_rst_held", z16t, 0);
    @(negedge clk);
    rst = 1'b0;
    a16 = 16'h0003;
    #1;
    chk("reg_release_wait", z16s, 0);
    @(posedge clk); #1;
    chk("reg_first_cap_s", z16s, 1);
    chk("reg_first_cap_t", z16t, 1);

    // WIDTH=8: directed points, then exhaustive.
    for (int k = 0; k < 6; k++) begin
      a8 = dir_a[k];
      #1;
      chk("w8_dir_scan", z8s, dir_z[k]);
      chk("w8_dir_tree", z8t, dir_z[k]);
    end
    for (int v = 0; v < 256; v++) begin
      a8 = 8'(v);
      #1;
      chk("w8_scan", z8s, ref_log2(v));
      chk("w8_tree", z8t, ref_log2(v));
    end

    // WIDTH=5: non-power-of-two, exhaustive with range check.
    a5 = 5'h10; #1;
    chk("w5_10_tree", z5t, 4);
    a5 = 5'h0F; #1;
    chk("w5_0F_tree", z5t, 3);
    for (int v = 0; v < 32; v++) begin
      a5 = 5'(v);
      #1;
      chk("w5_scan", z5s, ref_log2(v));
      chk("w5_tree", z5t, ref_log2(v));
      chk("w5_range_tree", 32'(z5t < 3'd5), 1);
    end

    // WIDTH=1: always 0.
    for (int v = 0; v < 2; v++) begin
      a1 = 1'(v);
      #1;
      chk("w1_scan", z1s, 0);
      chk("w1_tree", z1t, 0);
    end

    // WIDTH=32: directed then random.
    a32 = '0; #1;
    chk("w32_zero_scan", z32s, 0);
    chk("w32_zero_tree", z32t, 0);
    a32 = '1; #1;
    chk("w32_ones_scan", z32s, 31);
    chk("w32_ones_tree", z32t, 31);
    for (int k = 0; k < 32; k++) begin
      a32 = 32'd1 << k;
      #1;
      chk("w32_onehot_scan", z32s, k);
      chk("w32_onehot_tree", z32t, k);
    end
    for (int k = 0; k < 10000; k++) begin
      a32 = $urandom >> $urandom_range(0, 31);
      #1;
      chk("w32_rand_scan", z32s, ref_log2(a32));
      chk("w32_rand_tree", z32t, ref_log2(a32));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
